// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner.
//   key_w()      - key index width for a ROWS x COLS matrix
//   key_event_t  - packed FIFO entry {press, key}; key is zero-extended to MaxKeyW
//   settle_ok()  - column dwell must cover the row walk and the synchroniser
//   is_pow2()    - FIFO depth legality
package keypad_pkg;

    localparam int unsigned MaxKeyW = 8;

    typedef struct packed {
        logic               press;
        logic [MaxKeyW-1:0] key;
    } key_event_t;

    function automatic int unsigned key_w(input int unsigned rows, input int unsigned cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

    function automatic bit settle_ok(input int unsigned settle, input int unsigned rows);
        return (settle >= rows) && (settle >= 3);
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Synchronous show-ahead FIFO for keypad events.
//   clk, reset      - clock, asynchronous active-low reset
//   push, push_data - write request; ignored when full unless a pop happens in the same cycle
//   pop             - read request; ignored when empty
//   pop_data        - head entry (zero while empty)
//   full, empty     - occupancy flags
module keypad_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/keypad_scan.sv
// Keypad matrix scanner with per-key debounce, event FIFO and wait-for-key handshake.
//   clk, reset           - clock, asynchronous active-low reset
//   col_drive            - one-hot column strobe
//   row_sense            - raw row lines (1 = pressed), asynchronous
//   matrix               - debounced key state, bit row*COLS + col
//   evt_valid/ready      - event FIFO handshake; evt_key/evt_press describe the head
//   evt_overflow         - sticky dropped-event flag, cleared by overflow_clr
//   wait_req             - rising edge arms a wait for the next key release
//   wait_done, wait_key  - completion pulse and the releasing key
module keypad_scan
    import keypad_pkg::*;
#(
    parameter  int unsigned ROWS          = 4,
    parameter  int unsigned COLS          = 4,
    parameter  int unsigned SETTLE_CYCLES = 8,
    parameter  int unsigned DEBOUNCE      = 3,
    parameter  int unsigned FIFO_DEPTH    = 8,
    localparam int unsigned KEY_W         = key_w(ROWS, COLS)
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [COLS-1:0]      col_drive,
    input  logic [ROWS-1:0]      row_sense,
    output logic [ROWS*COLS-1:0] matrix,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [KEY_W-1:0]     evt_key,
    output logic                 evt_press,
    output logic                 evt_overflow,
    input  logic                 overflow_clr,
    input  logic                 wait_req,
    output logic                 wait_done,
    output logic [KEY_W-1:0]     wait_key
);

    localparam int unsigned NKEYS   = ROWS * COLS;
    localparam int unsigned COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned DWELL_W = $clog2(SETTLE_CYCLES);
    localparam int unsigned CNT_W   = $clog2(DEBOUNCE + 1);

    if (!settle_ok(SETTLE_CYCLES, ROWS)) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least max(ROWS, 3)");
    end
    if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (DEBOUNCE < 1 || KEY_W > MaxKeyW) begin : g_bad_misc
        $error("DEBOUNCE must be at least 1 and the key index must fit MaxKeyW");
    end

    // Column scan
    logic [COL_W-1:0]   col_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               last_dwell;

    assign last_dwell = (dwell_q == DWELL_W'(SETTLE_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q   <= '0;
            dwell_q <= '0;
        end else if (last_dwell) begin
            dwell_q <= '0;
            col_q   <= (col_q == COL_W'(COLS - 1)) ? '0 : col_q + 1'b1;
        end else begin
            dwell_q <= dwell_q + 1'b1;
        end
    end

    always_comb begin
        col_drive        = '0;
        col_drive[col_q] = 1'b1;
    end

    // Synchroniser, column sample and the row walk that follows it
    logic [ROWS-1:0]  sync1_q, sync2_q, sample_q;
    logic [COL_W-1:0] sample_col_q;
    logic             walk_q;
    logic [ROW_W-1:0] walk_row_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            sample_q     <= '0;
            sample_col_q <= '0;
            walk_q       <= 1'b0;
            walk_row_q   <= '0;
        end else begin
            sync1_q <= row_sense;
            sync2_q <= sync1_q;
            if (last_dwell) begin
                sample_q     <= sync2_q;
                sample_col_q <= col_q;
                walk_q       <= 1'b1;
                walk_row_q   <= '0;
            end else if (walk_q) begin
                if (walk_row_q == ROW_W'(ROWS - 1)) walk_q <= 1'b0;
                else                                walk_row_q <= walk_row_q + 1'b1;
            end
        end
    end

    // Debounce: one key per cycle, so at most one flip (and one FIFO push) per cycle
    logic [NKEYS-1:0] matrix_q, matrix_d;
    logic [CNT_W-1:0] cnt_q [NKEYS];
    logic [CNT_W-1:0] cnt_d [NKEYS];
    logic [KEY_W-1:0] walk_key;
    logic             walk_smp, flip;

    always_comb begin
        matrix_d = matrix_q;
        cnt_d    = cnt_q;
        flip     = 1'b0;
        walk_key = KEY_W'(walk_row_q) * KEY_W'(COLS) + KEY_W'(sample_col_q);
        walk_smp = sample_q[walk_row_q];
        if (walk_q) begin
            if (walk_smp == matrix_q[walk_key]) begin
                cnt_d[walk_key] = '0;
            end else if (cnt_q[walk_key] == CNT_W'(DEBOUNCE - 1)) begin
                matrix_d[walk_key] = walk_smp;
                cnt_d[walk_key]    = '0;
                flip               = 1'b1;
            end else begin
                cnt_d[walk_key] = cnt_q[walk_key] + 1'b1;
            end
        end
    end

    // Event FIFO and overflow flag
    key_event_t push_evt, head_evt;
    logic       fifo_full, fifo_empty, pop;
    logic       overflow_q, overflow_d;

    assign push_evt.press = walk_smp;
    assign push_evt.key   = MaxKeyW'(walk_key);
    assign pop            = evt_valid && evt_ready;

    keypad_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(key_event_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (flip),
        .push_data (push_evt),
        .pop       (pop),
        .pop_data  (head_evt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    if (KEY_W < MaxKeyW) begin : g_unused
        logic unused_key_bits;
        assign unused_key_bits = ^head_evt.key[MaxKeyW-1:KEY_W];
    end

    // A drop wins over a coincident clear so the loss is never hidden.
    always_comb begin
        overflow_d = overflow_q;
        if (overflow_clr)                    overflow_d = 1'b0;
        if (flip && fifo_full && !pop)       overflow_d = 1'b1;
    end

    // Wait-for-release handshake; a rise that coincides with a release only arms.
    logic             wait_req_q, armed_q, armed_d, done_q, done_d;
    logic [KEY_W-1:0] wait_key_q, wait_key_d;

    always_comb begin
        armed_d    = armed_q;
        done_d     = 1'b0;
        wait_key_d = wait_key_q;
        if (wait_req && !wait_req_q) begin
            armed_d = 1'b1;
        end else if (armed_q && !wait_req) begin
            armed_d = 1'b0;
        end else if (armed_q && flip && !walk_smp) begin
            done_d     = 1'b1;
            wait_key_d = walk_key;
            armed_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            matrix_q   <= '0;
            cnt_q      <= '{default: '0};
            overflow_q <= 1'b0;
            wait_req_q <= 1'b0;
            armed_q    <= 1'b0;
            done_q     <= 1'b0;
            wait_key_q <= '0;
        end else begin
            matrix_q   <= matrix_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            wait_req_q <= wait_req;
            armed_q    <= armed_d;
            done_q     <= done_d;
            wait_key_q <= wait_key_d;
        end
    end

    assign matrix       = matrix_q;
    assign evt_valid    = !fifo_empty;
    assign evt_key      = head_evt.key[KEY_W-1:0];
    assign evt_press    = head_evt.press;
    assign evt_overflow = overflow_q;
    assign wait_done    = done_q;
    assign wait_key     = wait_key_q;

endmodule
